clk_meter: RTL
==============

CLK_METER -- requirements
Module: clk_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 100000, is the gate window length in clk_in1 cycles (1 ms at 100 MHz), legal range 2 to 2^25-1.
REQ-002 Parameter CNT_W, default 24, is the width of the edge counter and of freq_cnt.
REQ-003 Port clk_in1, input, 1 bit: the single system clock (100 MHz); all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port meas_clk, input, 1 bit: the clock under measurement, asynchronous to clk_in1, frequency at most clk_in1/4.
REQ-006 Port en, input, 1 bit: level enable; high runs back-to-back windows.
REQ-007 Port freq_cnt, output, CNT_W bits: meas_clk rising edges counted in the last completed window.
REQ-008 Port valid, output, 1 bit: one-cycle pulse when freq_cnt updates.
REQ-009 Port ovf, output, 1 bit: the last completed window saturated the counter.
REQ-010 Port no_clk, output, 1 bit: the last completed window counted zero edges.

Function
REQ-011 meas_clk SHALL pass through a 2-flop synchronizer and then a rising-edge detector, so an edge registers at the third clk_in1 rising edge after the meas_clk rise.
REQ-012 The FSM SHALL have three states: IDLE, MEASURE and REPORT.
REQ-013 IDLE SHALL move to MEASURE on the first cycle en is sampled high, with the gate counter and edge counter cleared to 0.
REQ-014 MEASURE SHALL increment the gate counter every cycle and move to REPORT in the cycle the gate counter equals GATE_CYCLES-1.
REQ-015 A detected edge in any MEASURE cycle, including the last, SHALL increment the edge counter, which saturates at 2^CNT_W-1.
REQ-016 REPORT SHALL last exactly one cycle, in which it loads freq_cnt from the edge counter and asserts valid high.
REQ-017 In the REPORT cycle, ovf SHALL be set to 1 if saturation occurred in the window, else 0; no_clk SHALL be set to 1 if the count is 0, else 0.
REQ-018 In the REPORT cycle, the gate counter SHALL reload to 0 and the edge counter SHALL reload to 1 if an edge is detected that cycle, else 0, so no edge is lost between windows.
REQ-019 REPORT SHALL go to MEASURE if en is high, else to IDLE.
REQ-020 en going low during MEASURE SHALL abort to IDLE on the next cycle with no valid pulse; freq_cnt, ovf and no_clk hold their values.
REQ-021 freq_cnt, ovf and no_clk SHALL change only in the REPORT cycle or on reset.
REQ-022 valid SHALL never be high for two consecutive cycles.
REQ-023 Measured frequency is freq_cnt × clk_in1 / GATE_CYCLES; a steady input SHALL give a result within ±1 of the ideal count.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, both counters 0, synchronizer and edge flops 0, freq_cnt 0, valid 0, ovf 0, no_clk 0.
REQ-025 Reset mid-window SHALL discard the partial count, and no valid SHALL follow it.
REQ-026 After rst_n rises, the first valid SHALL occur no earlier than GATE_CYCLES+1 cycles after en is sampled high.

Configuration
REQ-027 With macro CLK_METER_FILTER_EN defined, the synchronized level SHALL be accepted only after 2 consecutive equal samples, rejecting 1-cycle glitches and adding exactly 1 cycle of edge latency.
REQ-028 Without CLK_METER_FILTER_EN, no filter SHALL be present and the REQ-011 latency SHALL apply unchanged.

Verification
REQ-029 GATE_CYCLES=1000, meas_clk 10 MHz (period 10 cycles), en held high -> valid every 1000 cycles, freq_cnt 100 ±1, ovf=0, no_clk=0.
REQ-030 GATE_CYCLES=100000, meas_clk 10 kHz -> freq_cnt 10 ±1, with steady continuous reporting.
REQ-031 GATE_CYCLES=1000, meas_clk held low -> freq_cnt=0, no_clk=1, valid still pulses every 1000 cycles.
REQ-032 CNT_W=4, GATE_CYCLES=1000, meas_clk 10 MHz -> freq_cnt=15, ovf=1; then meas_clk 1 MHz (period 100 cycles) -> freq_cnt 10 ±1, ovf=0.
REQ-033 en dropped at gate count 500 -> no valid pulse, outputs hold, FSM in IDLE; en re-raised -> full new window of 1000 cycles.
REQ-034 rst_n pulsed low at gate count 700 -> all outputs 0 at once; no valid until 1000+ cycles after en is sampled high again.

Source files
------------

// File: rtl/clk_meter.sv
// Gated frequency meter: counts meas_clk rising edges over GATE_CYCLES clk_in1 cycles.
// Define CLK_METER_FILTER_EN to add a 2-sample glitch filter after the synchronizer.
module clk_meter #(
    parameter int unsigned GATE_CYCLES = 100000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic             clk_in1,
    input  logic             rst_n,
    input  logic             meas_clk,
    input  logic             en,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             valid,
    output logic             ovf,
    output logic             no_clk
);

    localparam int unsigned      GW        = 25;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        REPORT
    } state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;
    logic             noclk_q, noclk_d;
    logic             valid_q, valid_d;

    logic sync1_q, sync2_q, prev_q;
    logic lvl;
    logic edge_det;

`ifdef CLK_METER_FILTER_EN
    logic filt_q;

    // Level is accepted only when both synchronizer stages agree.
    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
        end else if (sync1_q == sync2_q) begin
            filt_q <= sync2_q;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= meas_clk;
            sync2_q <= sync1_q;
            prev_q  <= lvl;
        end
    end

    assign edge_det = lvl & ~prev_q;

    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gate_q  <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
            noclk_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
            noclk_q <= noclk_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        noclk_d = noclk_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = MEASURE;
                    gate_d  = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            MEASURE: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    gate_d = gate_q + 1'b1;
                    if (edge_det) begin
                        // An edge arriving at full scale is lost and marks the window saturated.
                        if (cnt_q == CNT_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    if (gate_q == GATE_LAST) begin
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                freq_d  = cnt_q;
                ovf_d   = sat_q;
                noclk_d = (cnt_q == '0);
                valid_d = 1'b1;
                gate_d  = '0;
                // An edge seen during the report cycle seeds the next window.
                cnt_d   = CNT_W'(edge_det);
                sat_d   = 1'b0;
                state_d = en ? MEASURE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign freq_cnt = freq_q;
    assign valid    = valid_q;
    assign ovf      = ovf_q;
    assign no_clk   = noclk_q;

endmodule
